// File: rtl/register_file_writeback_if.sv
// register_file_writeback_if: ALU/load result inputs, register file write port and forwarding lookup
// bundled between the pipeline (master) and the write-back stage (slave).
interface register_file_writeback_if #(
    parameter int WIDTH     = 32,
    parameter int REG_WIDTH = 5
);
    logic                 alu_valid;
    logic [REG_WIDTH-1:0] alu_rd;
    logic [WIDTH-1:0]     alu_data;
    logic                 ld_valid;
    logic                 ld_ready;
    logic [REG_WIDTH-1:0] ld_rd;
    logic [WIDTH-1:0]     ld_data;
    logic                 wr;
    logic [REG_WIDTH-1:0] waddr;
    logic [WIDTH-1:0]     wdata;
    logic [REG_WIDTH-1:0] rs1;
    logic [REG_WIDTH-1:0] rs2;
    logic                 fwd1_hit;
    logic [WIDTH-1:0]     fwd1_data;
    logic                 fwd2_hit;
    logic [WIDTH-1:0]     fwd2_data;
    logic                 busy;

    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, rs1, rs2,
        input  ld_ready, wr, waddr, wdata, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, busy
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, rs1, rs2,
        output ld_ready, wr, waddr, wdata, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, busy
    );
endinterface

// File: rtl/register_file_writeback.sv
// register_file_writeback: merges never-stalling ALU results and buffered load results onto the
// single register file write port, and forwards results not yet visible in the register file.
module register_file_writeback #(
    parameter int WIDTH     = 32,
    parameter int REG_WIDTH = 5,
    parameter int LD_DEPTH  = 2
) (
    input logic                         clk,
    input logic                         reset,
    register_file_writeback_if.slave    wb
);
    localparam int PW = LD_DEPTH > 1 ? $clog2(LD_DEPTH) : 1;
    localparam int CW = $clog2(LD_DEPTH + 1);

    logic [LD_DEPTH-1:0]  buf_vld_q, buf_vld_d;
    logic [REG_WIDTH-1:0] buf_rd_q   [LD_DEPTH];
    logic [REG_WIDTH-1:0] buf_rd_d   [LD_DEPTH];
    logic [WIDTH-1:0]     buf_data_q [LD_DEPTH];
    logic [WIDTH-1:0]     buf_data_d [LD_DEPTH];
    logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 wr_q, wr_d;
    logic [REG_WIDTH-1:0] waddr_q, waddr_d;
    logic [WIDTH-1:0]     wdata_q, wdata_d;

    logic alu_sel, ld_fire, empty, pop, head_wr, direct, push;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(LD_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Buffer entries are younger than the output register, so they win the lookup.
    function automatic logic [WIDTH:0] lookup(input logic [REG_WIDTH-1:0] rs);
        logic [WIDTH:0] r;
        r = '0;
        if (rs != '0) begin
            if (wr_q && waddr_q == rs) r = {1'b1, wdata_q};
            for (int i = 0; i < LD_DEPTH; i++)
                if (buf_vld_q[i] && buf_rd_q[i] == rs) r = {1'b1, buf_data_q[i]};
        end
        return r;
    endfunction

    assign wb.ld_ready = !reset && count_q < CW'(LD_DEPTH);
    assign empty       = count_q == '0;
    assign alu_sel     = wb.alu_valid && wb.alu_rd != '0;
    assign ld_fire     = wb.ld_valid && wb.ld_ready;
    assign pop         = !alu_sel && !empty;
    assign head_wr     = pop && buf_vld_q[head_q];
    assign direct      = !alu_sel && empty && ld_fire && wb.ld_rd != '0;
    assign push        = ld_fire && wb.ld_rd != '0 && !direct && !(alu_sel && wb.alu_rd == wb.ld_rd);

    assign wr_d    = alu_sel || head_wr || direct;
    assign waddr_d = alu_sel ? wb.alu_rd : head_wr ? buf_rd_q[head_q] : direct ? wb.ld_rd : waddr_q;
    assign wdata_d = alu_sel ? wb.alu_data : head_wr ? buf_data_q[head_q] : direct ? wb.ld_data : wdata_q;

    assign head_d  = pop ? nxt(head_q) : head_q;
    assign tail_d  = push ? nxt(tail_q) : tail_q;
    assign count_d = count_q + CW'(push) - CW'(pop);

    // Kills first, then pop clear, then push; a push never lands on the popped slot.
    always_comb begin
        buf_vld_d  = buf_vld_q;
        buf_rd_d   = buf_rd_q;
        buf_data_d = buf_data_q;
        for (int i = 0; i < LD_DEPTH; i++)
            if ((alu_sel && buf_rd_q[i] == wb.alu_rd) || (push && buf_rd_q[i] == wb.ld_rd))
                buf_vld_d[i] = 1'b0;
        if (pop) buf_vld_d[head_q] = 1'b0;
        if (push) begin
            buf_vld_d[tail_q]  = 1'b1;
            buf_rd_d[tail_q]   = wb.ld_rd;
            buf_data_d[tail_q] = wb.ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_vld_q  <= '0;
            buf_rd_q   <= '{default: '0};
            buf_data_q <= '{default: '0};
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            wr_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            buf_vld_q  <= buf_vld_d;
            buf_rd_q   <= buf_rd_d;
            buf_data_q <= buf_data_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            wr_q       <= wr_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign wb.wr    = wr_q;
    assign wb.waddr = waddr_q;
    assign wb.wdata = wdata_q;
    assign wb.busy  = !empty || wr_q;
    assign {wb.fwd1_hit, wb.fwd1_data} = lookup(wb.rs1);
    assign {wb.fwd2_hit, wb.fwd2_data} = lookup(wb.rs2);
endmodule

// File: tb/tb_register_file_writeback.sv
// tb_register_file_writeback: scenario tasks with a write scoreboard; every register file write
// is popped from the expected queue in order, and unexpected writes are flagged.
module tb_register_file_writeback;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    register_file_writeback_if #(.WIDTH(32), .REG_WIDTH(5)) wb ();
    register_file_writeback #(.WIDTH(32), .REG_WIDTH(5), .LD_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .wb(wb)
    );

    int errors = 0;
    int checks = 0;
    logic [36:0] sbq [$];

    always @(negedge clk) begin
        if (wb.wr === 1'b1) begin
            logic [36:0] e;
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got waddr=%0d wdata=%h, required no write", wb.waddr, wb.wdata);
            end else begin
                e = sbq.pop_front();
                if ({wb.waddr, wb.wdata} !== e) begin
                    errors++;
                    $display("FAIL write_order got waddr=%0d wdata=%h, required waddr=%0d wdata=%h",
                             wb.waddr, wb.wdata, e[36:32], e[31:0]);
                end
            end
        end
    end

    task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lr, input logic [31:0] ld);
        wb.alu_valid = av; wb.alu_rd = ar; wb.alu_data = ad;
        wb.ld_valid = lv; wb.ld_rd = lr; wb.ld_data = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        wb.rs1 = 5'd3;
        wb.rs2 = 5'd0;
        repeat (2) tick();
        @(negedge clk);
        checks++;
        if ({wb.wr, wb.waddr, wb.wdata, wb.busy, wb.ld_ready, wb.fwd1_hit, wb.fwd2_hit} !== 43'd0) begin
            errors++;
            $display("FAIL reset_state got wr=%b waddr=%0d wdata=%h busy=%b ld_ready=%b hit=%b%b, required all 0",
                     wb.wr, wb.waddr, wb.wdata, wb.busy, wb.ld_ready, wb.fwd1_hit, wb.fwd2_hit);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_alu_basic();
        wb.rs1 = 5'd3;
        drive(1, 3, 32'hAA, 0, 0, 0);
        sbq.push_back({5'd3, 32'hAA});
        tick();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({wb.wr, wb.waddr, wb.wdata} !== {1'b1, 5'd3, 32'hAA}) begin
            errors++;
            $display("FAIL alu_latency got wr=%b waddr=%0d wdata=%h, required wr=1 waddr=3 wdata=aa",
                     wb.wr, wb.waddr, wb.wdata);
        end
        checks++;
        if ({wb.fwd1_hit, wb.fwd1_data} !== {1'b1, 32'hAA}) begin
            errors++;
            $display("FAIL fwd_from_wr got hit=%b data=%h, required hit=1 data=aa", wb.fwd1_hit, wb.fwd1_data);
        end
        tick();
    endtask

    task automatic test_alu_load();
        wb.rs1 = 5'd2;
        drive(1, 1, 32'h11, 1, 2, 32'h22);
        sbq.push_back({5'd1, 32'h11});
        sbq.push_back({5'd2, 32'h22});
        @(negedge clk);
        checks++;
        if ({wb.ld_ready, wb.fwd1_hit} !== 2'b10) begin
            errors++;
            $display("FAIL same_cycle_inputs got ld_ready=%b fwd1_hit=%b, required ld_ready=1 fwd1_hit=0",
                     wb.ld_ready, wb.fwd1_hit);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({wb.wr, wb.waddr, wb.fwd1_hit, wb.fwd1_data} !== {1'b1, 5'd1, 1'b1, 32'h22}) begin
            errors++;
            $display("FAIL fwd_from_buffer got wr=%b waddr=%0d hit=%b data=%h, required wr=1 waddr=1 hit=1 data=22",
                     wb.wr, wb.waddr, wb.fwd1_hit, wb.fwd1_data);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({wb.wr, wb.waddr} !== {1'b1, 5'd2}) begin
            errors++;
            $display("FAIL load_follows got wr=%b waddr=%0d, required wr=1 waddr=2", wb.wr, wb.waddr);
        end
        idle(2);
    endtask

    task automatic test_backpressure();
        int acc = 0;
        for (int k = 0; k < 12; k++) begin
            drive(k < 5, 5'(10 + k), 32'(k + 'h100), acc < 3, 5'(20 + acc), 32'(acc + 'h200));
            if (k < 5) sbq.push_back({5'(10 + k), 32'(k + 'h100)});
            if (k == 5) for (int j = 0; j < 3; j++) sbq.push_back({5'(20 + j), 32'(j + 'h200)});
            @(negedge clk);
            if (k >= 2 && k < 5) begin
                checks++;
                if (wb.ld_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ld_ready_full k=%0d got %b, required 0", k, wb.ld_ready);
                end
            end
            if (wb.ld_valid && wb.ld_ready) acc++;
            tick();
        end
        checks++;
        if (acc != 3) begin
            errors++;
            $display("FAIL loads_accepted got %0d, required 3", acc);
        end
        idle(2);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain_backpressure got %0d pending writes, required 0", sbq.size());
        end
    endtask

    task automatic test_alu_kill();
        wb.rs1 = 5'd5;
        drive(1, 6, 32'h66, 1, 5, 32'h55);
        sbq.push_back({5'd6, 32'h66});
        tick();
        drive(1, 5, 32'h11, 0, 0, 0);
        sbq.push_back({5'd5, 32'h11});
        @(negedge clk);
        checks++;
        if ({wb.fwd1_hit, wb.fwd1_data} !== {1'b1, 32'h55}) begin
            errors++;
            $display("FAIL fwd_buffered_rd5 got hit=%b data=%h, required hit=1 data=55", wb.fwd1_hit, wb.fwd1_data);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({wb.fwd1_hit, wb.fwd1_data} !== {1'b1, 32'h11}) begin
            errors++;
            $display("FAIL fwd_after_kill got hit=%b data=%h, required hit=1 data=11", wb.fwd1_hit, wb.fwd1_data);
        end
        idle(4);
        checks++;
        if (wb.busy !== 1'b0 || sbq.size() != 0) begin
            errors++;
            $display("FAIL alu_kill_drain got busy=%b pending=%0d, required busy=0 pending=0", wb.busy, sbq.size());
        end
    endtask

    task automatic test_x0();
        wb.rs1 = 5'd0;
        wb.rs2 = 5'd0;
        drive(1, 0, 32'h77, 1, 0, 32'h88);
        @(negedge clk);
        checks++;
        if ({wb.ld_ready, wb.fwd1_hit, wb.fwd2_hit} !== 3'b100) begin
            errors++;
            $display("FAIL x0_handshake got ld_ready=%b hit=%b%b, required ld_ready=1 hit=00",
                     wb.ld_ready, wb.fwd1_hit, wb.fwd2_hit);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({wb.wr, wb.busy} !== 2'b00) begin
            errors++;
            $display("FAIL x0_no_write got wr=%b busy=%b, required wr=0 busy=0", wb.wr, wb.busy);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        wb.rs2 = 5'd4;
        drive(0, 0, 0, 1, 4, 32'h44);
        sbq.push_back({5'd4, 32'h44});
        tick();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({wb.wr, wb.waddr, wb.busy, wb.fwd2_hit, wb.fwd2_data} !== {1'b1, 5'd4, 1'b1, 1'b1, 32'h44}) begin
            errors++;
            $display("FAIL direct_load got wr=%b waddr=%0d busy=%b hit=%b data=%h, required 1 4 1 1 44",
                     wb.wr, wb.waddr, wb.busy, wb.fwd2_hit, wb.fwd2_data);
        end
        tick();
        drive(1, 13, 32'h13, 1, 13, 32'hDD);
        sbq.push_back({5'd13, 32'h13});
        tick();
        drive(1, 1, 32'hA1, 1, 14, 32'hE1);
        sbq.push_back({5'd1, 32'hA1});
        tick();
        drive(1, 2, 32'hA2, 1, 14, 32'hE2);
        sbq.push_back({5'd2, 32'hA2});
        tick();
        sbq.push_back({5'd14, 32'hE2});
        idle(5);
        checks++;
        if (wb.busy !== 1'b0 || sbq.size() != 0) begin
            errors++;
            $display("FAIL kill_rules_drain got busy=%b pending=%0d, required busy=0 pending=0", wb.busy, sbq.size());
        end
    endtask

    task automatic test_reset_flush();
        drive(1, 7, 32'h70, 1, 8, 32'h80);
        sbq.push_back({5'd7, 32'h70});
        tick();
        drive(1, 9, 32'h90, 1, 12, 32'hC0);
        sbq.push_back({5'd9, 32'h90});
        @(negedge clk);
        checks++;
        if (wb.ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL ld_ready_one_entry got %b, required 1", wb.ld_ready);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({wb.busy, wb.ld_ready} !== 2'b10) begin
            errors++;
            $display("FAIL full_in_reset got busy=%b ld_ready=%b, required busy=1 ld_ready=0", wb.busy, wb.ld_ready);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({wb.wr, wb.busy, wb.ld_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flush got wr=%b busy=%b ld_ready=%b, required 0 0 0", wb.wr, wb.busy, wb.ld_ready);
        end
        tick();
        reset = 1'b0;
        idle(4);
        checks++;
        if (sbq.size() != 0 || wb.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flush_end got pending=%0d busy=%b, required 0 0", sbq.size(), wb.busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_basic();
        test_alu_load();
        test_backpressure();
        test_alu_kill();
        test_x0();
        test_back_to_back();
        test_reset_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
